// File: rtl/mac_filter_decimator.sv
// Output stage behind the single-MAC FIR filter. It decimates, rounds, scales and saturates
// each kept sample, then buffers the result in a first-word-fall-through FIFO with valid/ready.
module mac_filter_decimator #(
  parameter int unsigned DATA_W     = 18,
  parameter int unsigned OUT_W      = 16,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          Clk_i,
  input  logic                          Rst_i,
  input  logic [DATA_W-1:0]             Data_i,
  input  logic                          DataNd_i,
  input  logic [3:0]                    Decim_i,
  input  logic [1:0]                    Shift_i,
  output logic [OUT_W-1:0]              Data_o,
  output logic                          DataValid_o,
  input  logic                          DataReady_i,
  output logic [$clog2(FIFO_DEPTH):0]   Level_o,
  output logic                          Overflow_o
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned SUM_W = DATA_W + 1;
  localparam logic [PTR_W:0] FULL_LVL = (PTR_W + 1)'(FIFO_DEPTH);

  logic [3:0]             r_phase;
  logic                   r_a_vld;
  logic [SUM_W-1:0]       r_a_sum;

  logic [2:0]             w_shift_tot;
  logic [SUM_W-1:0]       w_round;
  logic [SUM_W-1:0]       w_sum;
  logic signed [SUM_W-1:0] w_shifted;
  logic                   w_fits;
  logic [OUT_W-1:0]       w_sat;

  logic [OUT_W-1:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       r_wr_ptr;
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [PTR_W:0]         r_count;
  logic                   r_overflow;

  logic                   w_empty;
  logic                   w_full;
  logic                   w_rd;
  logic                   w_wr;

  // Stage A: round-half-up offset is 2^(s-1) with s = 2 + Shift_i.
  assign w_shift_tot = {1'b0, Shift_i} + 3'd2;
  assign w_round     = SUM_W'(1) << (w_shift_tot - 3'd1);
  assign w_sum       = {Data_i[DATA_W-1], Data_i} + w_round;

  always_ff @(posedge Clk_i) begin
    if (!Rst_i) begin
      r_phase <= 4'd0;
      r_a_vld <= 1'b0;
      r_a_sum <= '0;
    end else begin
      r_a_vld <= DataNd_i && (r_phase == 4'd0);
      if (DataNd_i) begin
        r_a_sum <= w_sum;
        r_phase <= (r_phase >= Decim_i) ? 4'd0 : r_phase + 4'd1;
      end
    end
  end

  // Stage B: the result fits when all bits above the output sign bit agree with it.
  assign w_shifted = $signed(r_a_sum) >>> w_shift_tot;
  assign w_fits    = (&w_shifted[SUM_W-1:OUT_W-1]) || !(|w_shifted[SUM_W-1:OUT_W-1]);

  always_comb begin
    w_sat = w_shifted[OUT_W-1:0];
    if (!w_fits) begin
      w_sat = w_shifted[SUM_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_LVL);
  assign w_rd    = !w_empty && DataReady_i;
  // A full FIFO still accepts the write when the head leaves on the same edge.
  assign w_wr    = r_a_vld && (!w_full || w_rd);

  always_ff @(posedge Clk_i) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= w_sat;
    end
  end

  always_ff @(posedge Clk_i) begin
    if (!Rst_i) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
        2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
        default: r_count <= r_count;
      endcase
      if (r_a_vld && w_full && !w_rd) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign Data_o      = w_empty ? '0 : r_mem[r_rd_ptr];
  assign DataValid_o = !w_empty;
  assign Level_o     = r_count;
  assign Overflow_o  = r_overflow;

endmodule
